// File: rtl/gpi_1_capture.sv
// GPI_1 word producer: synchronizes board/BMC/ME inputs, debounces the
// force-recovery strap, latches W1C sticky events and packs them into gpi_1.
module gpi_1_capture #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        areset,
  input  logic        rst_rsmrst_pld_r_n,
  input  logic        rst_srst_bmc_pld_r_n,
  input  logic        fm_me_pfr_1,
  input  logic        fm_me_pfr_2,
  input  logic        pltrst_n,
  input  logic        bmc_spi_ibb_access,
  input  logic        fm_pfr_force_recovery_n,
  input  logic        hpfr_in,
  input  logic        legacy,
  input  logic        hpfr_active,
  input  logic        clr_valid,
  input  logic [31:0] clr_mask,
  output logic [31:0] gpi_1,
  output logic        gpi_1_change
);

  localparam int          CW          = $clog2(DEBOUNCE_CYCLES);
  localparam logic [8:0]  SYNC_RST    = 9'h020;  // force-recovery lane idles high
  localparam logic [31:0] STICKY_MASK = 32'h0000_0030;
  localparam logic [31:0] GPI_RST     = 32'h0000_0040;

  typedef enum logic {ST_STABLE, ST_COUNTING} db_state_t;

  // Lane order: 0 rsmrst, 1 srst, 2 me1, 3 me2, 4 pltrst, 5 force_recovery,
  // 6 hpfr_in, 7 legacy, 8 hpfr_active.
  logic [8:0] raw;
  logic [8:0] sync_q [SYNC_STAGES];
  logic [8:0] sync;
  logic [SYNC_STAGES-1:0] primed_q;
  logic       primed;

  assign raw = {hpfr_active, legacy, hpfr_in, fm_pfr_force_recovery_n, pltrst_n,
                fm_me_pfr_2, fm_me_pfr_1, rst_srst_bmc_pld_r_n, rst_rsmrst_pld_r_n};
  assign sync   = sync_q[SYNC_STAGES-1];
  assign primed = primed_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_RST;
      primed_q <= '0;
    end else begin
      sync_q[0] <= raw;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      primed_q <= {primed_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // Force-recovery debounce
  db_state_t db_state, db_state_next;
  logic [CW-1:0] db_cnt, db_cnt_next;
  logic          stable, stable_next;
  logic          db_diff, db_done;

  assign db_diff = sync[5] ^ stable;
  assign db_done = db_diff && (db_cnt == CW'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      db_state <= ST_STABLE;
      db_cnt   <= '0;
      stable   <= 1'b1;
    end else begin
      db_state <= db_state_next;
      db_cnt   <= db_cnt_next;
      stable   <= stable_next;
    end
  end

  always_comb begin
    db_state_next = db_state;
    unique case (db_state)
      ST_STABLE:   if (db_diff) db_state_next = ST_COUNTING;
      ST_COUNTING: if (!db_diff || db_done) db_state_next = ST_STABLE;
      default:     db_state_next = ST_STABLE;
    endcase
  end

  always_comb begin
    db_cnt_next = '0;
    stable_next = stable;
    if (db_done) stable_next = sync[5];
    else if (db_diff) db_cnt_next = db_cnt + CW'(1);
  end

  // The pltrst lane is only trusted once the chain has flushed its reset
  // zeros, so a pltrst_n already high at reset release is not seen as a rise.
  logic pl_prev, pl_rise;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) pl_prev <= 1'b1;
    else if (primed) pl_prev <= sync[4];
  end

  assign pl_rise = primed & sync[4] & ~pl_prev;

  // Output word assembly; sticky set wins over a same-cycle clear.
  logic [31:0] clr_w1c, set_vec, level_vec, gpi_next;
  logic        started;

  assign clr_w1c   = {32{clr_valid}} & clr_mask & STICKY_MASK;
  assign set_vec   = {26'b0, bmc_spi_ibb_access, pl_rise, 4'b0};
  assign level_vec = {22'b0, sync[8:6], stable, 2'b0, sync[3:0]};
  assign gpi_next  = level_vec | set_vec | (gpi_1 & STICKY_MASK & ~clr_w1c);

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      gpi_1        <= GPI_RST;
      gpi_1_change <= 1'b0;
      started      <= 1'b0;
    end else begin
      gpi_1        <= gpi_next;
      gpi_1_change <= started && (gpi_next != gpi_1);
      started      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_gpi_1_capture.sv
// Bench for gpi_1_capture: directed vector table, reset corner cases and
// randomized cycles checked against a history-based reference model.
module tb_gpi_1_capture;

  localparam int S = 2;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        areset;
  logic        rst_rsmrst_pld_r_n, rst_srst_bmc_pld_r_n, fm_me_pfr_1, fm_me_pfr_2;
  logic        pltrst_n, bmc_spi_ibb_access, fm_pfr_force_recovery_n;
  logic        hpfr_in, legacy, hpfr_active, clr_valid;
  logic [31:0] clr_mask;
  logic [31:0] gpi_1;
  logic        gpi_1_change;

  always #5 clk = ~clk;

  gpi_1_capture #(.SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .areset(areset),
    .rst_rsmrst_pld_r_n(rst_rsmrst_pld_r_n), .rst_srst_bmc_pld_r_n(rst_srst_bmc_pld_r_n),
    .fm_me_pfr_1(fm_me_pfr_1), .fm_me_pfr_2(fm_me_pfr_2), .pltrst_n(pltrst_n),
    .bmc_spi_ibb_access(bmc_spi_ibb_access), .fm_pfr_force_recovery_n(fm_pfr_force_recovery_n),
    .hpfr_in(hpfr_in), .legacy(legacy), .hpfr_active(hpfr_active),
    .clr_valid(clr_valid), .clr_mask(clr_mask),
    .gpi_1(gpi_1), .gpi_1_change(gpi_1_change)
  );

  typedef struct packed {
    logic rsm, srst, me1, me2, pl, bmc, frc, hin, leg, hact, clrv;
    logic [31:0] mask;
  } in_t;

  typedef struct {
    int          rep;
    in_t         in;
    logic [31:0] eg;
    logic        ec;
  } vec_t;

  in_t         hist [0:4095];
  int          k;
  logic        stable_m, s4, s5;
  logic [31:0] exp_prev;
  int          n_cmp = 0;
  int          n_fail = 0;

  function automatic in_t idle_in();
    in_t v = '0;
    v.pl  = 1'b1;
    v.frc = 1'b1;
    return v;
  endfunction

  // Input seen at cycle j; before reset release the board is taken as idle.
  function automatic in_t lag(int j);
    if (j >= 1) return hist[j];
    return idle_in();
  endfunction

  function automatic vec_t row(int rep, bit leg, bit hact, bit pl, bit frc, bit bmc,
                               bit clrv, logic [31:0] mask, logic [31:0] eg, bit ec);
    vec_t r;
    r.in      = idle_in();
    r.in.leg  = leg;  r.in.hact = hact; r.in.pl = pl; r.in.frc = frc;
    r.in.bmc  = bmc;  r.in.clrv = clrv; r.in.mask = mask;
    r.rep = rep; r.eg = eg; r.ec = ec;
    return r;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, k);
    end
  endtask

  task automatic model_reset();
    k = 0; stable_m = 1'b1; s4 = 1'b0; s5 = 1'b0; exp_prev = 32'h40;
  endtask

  task automatic drive(in_t v);
    rst_rsmrst_pld_r_n = v.rsm;  rst_srst_bmc_pld_r_n = v.srst;
    fm_me_pfr_1 = v.me1;  fm_me_pfr_2 = v.me2;  pltrst_n = v.pl;
    bmc_spi_ibb_access = v.bmc;  fm_pfr_force_recovery_n = v.frc;
    hpfr_in = v.hin;  legacy = v.leg;  hpfr_active = v.hact;
    clr_valid = v.clrv;  clr_mask = v.mask;
  endtask

  // One clock: drive at negedge, predict, compare at the following negedge.
  task automatic step(in_t v);
    in_t a, b;
    logic [31:0] e;
    logic ch, all_diff;
    drive(v);
    k++;
    hist[k] = v;
    a = lag(k - S);
    b = lag(k - S - 1);
    s4 = (a.pl & ~b.pl) | (s4 & ~(v.clrv & v.mask[4]));
    s5 = v.bmc | (s5 & ~(v.clrv & v.mask[5]));
    e = '0;
    e[0] = a.rsm; e[1] = a.srst; e[2] = a.me1; e[3] = a.me2;
    e[4] = s4;    e[5] = s5;     e[6] = stable_m;
    e[7] = a.hin; e[8] = a.leg;  e[9] = a.hact;
    // Strap flips once the last D synchronized samples all disagree with it.
    all_diff = 1'b1;
    for (int i = k - D + 1; i <= k; i++)
      if (lag(i - S).frc == stable_m) all_diff = 1'b0;
    if (all_diff) stable_m = ~stable_m;
    ch = (k >= 2) && (e != exp_prev);
    exp_prev = e;
    @(negedge clk);
    check("model gpi_1", gpi_1, e);
    check("model gpi_1_change", {31'b0, gpi_1_change}, {31'b0, ch});
  endtask

  function automatic in_t rand_in(in_t prev);
    in_t v;
    int  sel;
    v = '0;
    v.rsm = 1'($urandom_range(0, 1)); v.srst = 1'($urandom_range(0, 1));
    v.me1 = 1'($urandom_range(0, 1)); v.me2  = 1'($urandom_range(0, 1));
    v.hin = 1'($urandom_range(0, 1)); v.leg  = 1'($urandom_range(0, 1));
    v.hact = 1'($urandom_range(0, 1));
    v.pl  = ($urandom_range(0, 5) == 0) ? ~prev.pl  : prev.pl;
    v.frc = ($urandom_range(0, 4) == 0) ? ~prev.frc : prev.frc;
    v.bmc = ($urandom_range(0, 7) == 0);
    v.clrv = ($urandom_range(0, 3) == 0);
    sel = $urandom_range(0, 5);
    case (sel)
      0: v.mask = 32'h0;
      1: v.mask = 32'h10;
      2: v.mask = 32'h20;
      3: v.mask = 32'h30;
      4: v.mask = 32'hFFFF_FFFF;
      default: v.mask = $urandom;
    endcase
    return v;
  endfunction

  vec_t tbl [25];
  in_t  v, cur;

  initial begin
    tbl[0]  = row(3, 0, 0, 1, 1, 0, 0, 32'h0,         32'h040, 0);
    tbl[1]  = row(2, 1, 0, 1, 1, 0, 0, 32'h0,         32'h040, 0);
    tbl[2]  = row(1, 1, 0, 1, 1, 0, 0, 32'h0,         32'h140, 1);
    tbl[3]  = row(1, 1, 0, 1, 1, 0, 0, 32'h0,         32'h140, 0);
    tbl[4]  = row(2, 0, 1, 1, 1, 0, 0, 32'h0,         32'h140, 0);
    tbl[5]  = row(1, 0, 1, 1, 1, 0, 0, 32'h0,         32'h240, 1);
    tbl[6]  = row(1, 0, 1, 0, 1, 0, 0, 32'h0,         32'h240, 0);
    tbl[7]  = row(2, 0, 1, 1, 1, 0, 0, 32'h0,         32'h240, 0);
    tbl[8]  = row(1, 0, 1, 1, 1, 0, 0, 32'h0,         32'h250, 1);
    tbl[9]  = row(1, 0, 1, 1, 1, 0, 1, 32'h10,        32'h240, 1);
    tbl[10] = row(1, 0, 1, 0, 1, 0, 0, 32'h0,         32'h240, 0);
    tbl[11] = row(2, 0, 1, 1, 1, 0, 0, 32'h0,         32'h240, 0);
    tbl[12] = row(1, 0, 1, 1, 1, 0, 1, 32'h10,        32'h250, 1);
    tbl[13] = row(1, 0, 1, 1, 1, 0, 1, 32'h10,        32'h240, 1);
    tbl[14] = row(1, 0, 1, 1, 1, 1, 0, 32'h0,         32'h260, 1);
    tbl[15] = row(2, 0, 1, 1, 1, 0, 0, 32'h0,         32'h260, 0);
    tbl[16] = row(1, 0, 1, 1, 1, 0, 1, 32'hFFFF_FFFF, 32'h240, 1);
    tbl[17] = row(2, 0, 1, 1, 1, 0, 0, 32'h0,         32'h240, 0);
    tbl[18] = row(3, 0, 1, 1, 0, 0, 0, 32'h0,         32'h240, 0);
    tbl[19] = row(6, 0, 1, 1, 1, 0, 0, 32'h0,         32'h240, 0);
    tbl[20] = row(6, 0, 1, 1, 0, 0, 0, 32'h0,         32'h240, 0);
    tbl[21] = row(1, 0, 1, 1, 0, 0, 0, 32'h0,         32'h200, 1);
    tbl[22] = row(3, 0, 1, 1, 0, 0, 0, 32'h0,         32'h200, 0);
    tbl[23] = row(6, 0, 1, 1, 1, 0, 0, 32'h0,         32'h200, 0);
    tbl[24] = row(1, 0, 1, 1, 1, 0, 0, 32'h0,         32'h240, 1);

    // Reset state
    areset = 1'b1;
    drive(idle_in());
    repeat (2) @(negedge clk);
    check("reset gpi_1", gpi_1, 32'h40);
    check("reset gpi_1_change", {31'b0, gpi_1_change}, 32'h0);
    model_reset();
    areset = 1'b0;

    // Idle after release: nothing may change, including bit 4
    for (int i = 0; i < 20; i++) step(idle_in());

    // Directed vector table
    for (int r = 0; r < 25; r++) begin
      for (int n = 0; n < tbl[r].rep; n++) step(tbl[r].in);
      check($sformatf("row%0d gpi_1", r), gpi_1, tbl[r].eg);
      check($sformatf("row%0d gpi_1_change", r), {31'b0, gpi_1_change}, {31'b0, tbl[r].ec});
    end

    // Reset in the middle of a debounce count with bit 5 set
    v = idle_in(); v.bmc = 1'b1;
    step(v);
    v = idle_in(); v.frc = 1'b0;
    for (int i = 0; i < 4; i++) step(v);
    areset = 1'b1;
    #1;
    check("async reset gpi_1", gpi_1, 32'h40);
    check("async reset gpi_1_change", {31'b0, gpi_1_change}, 32'h0);
    @(negedge clk);
    check("held reset gpi_1", gpi_1, 32'h40);
    model_reset();
    areset = 1'b0;
    for (int i = 0; i < 8; i++) step(v);
    check("fresh debounce gpi_1", gpi_1, 32'h00);
    for (int i = 0; i < 8; i++) step(idle_in());
    check("recovered gpi_1", gpi_1, 32'h40);

    // Randomized traffic
    cur = idle_in();
    for (int i = 0; i < 800; i++) begin
      cur = rand_in(cur);
      step(cur);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/gpi_1_capture.md
Name: gpi_1_capture

Overview:
- Upstream producer of the GPI_1 general-purpose-input word read by the PFR Nios.
- Synchronizes raw board/BMC/ME inputs and debounces the force-recovery strap.
- Latches sticky event bits and packs everything into GPI_1 at the fixed bit positions (bits 0..9, 10..31 unused).
- Firmware clears sticky bits through a write-1-to-clear strobe.

Parameters:
- SYNC_STAGES, 2, synchronizer depth for async inputs (min 2).
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles required before the force-recovery bit changes (min 2).

Ports:
- clk  in  1  system clock.
- areset  in  1  asynchronous active-high reset.
- rst_rsmrst_pld_r_n  in  1  async level, feeds bit 0.
- rst_srst_bmc_pld_r_n  in  1  async level, feeds bit 1.
- fm_me_pfr_1  in  1  async level, feeds bit 2.
- fm_me_pfr_2  in  1  async level, feeds bit 3.
- pltrst_n  in  1  async level; a rising edge sets sticky bit 4.
- bmc_spi_ibb_access  in  1  clk-synchronous, active high; sets sticky bit 5.
- fm_pfr_force_recovery_n  in  1  async strap, debounced, feeds bit 6.
- hpfr_in  in  1  async level, feeds bit 7.
- legacy  in  1  async level, feeds bit 8.
- hpfr_active  in  1  async level, feeds bit 9.
- clr_valid  in  1  one-cycle clear strobe.
- clr_mask  in  32  W1C mask, sampled when clr_valid=1.
- gpi_1  out  32  packed GPI_1 word (registered).
- gpi_1_change  out  1  one-cycle pulse when gpi_1 differs from its previous value.

Behaviour:
- Reset values:
  - gpi_1 = 0x00000040 (only bit 6 set = recovery not forced); gpi_1_change = 0.
  - All synchronizer flops = 0, except the force-recovery chain, which resets to 1.
  - pltrst previous-sample register = 1; debounce counter = 0.
- Level bits 0,1,2,3,7,8,9:
  - Each input passes through its own SYNC_STAGES flop chain; gpi_1[n] <= sync output.
  - Latency from input change to gpi_1 = SYNC_STAGES+1 clk edges.
- Bit 6 debounce (states STABLE/COUNTING):
  - STABLE: sync value equals the stable bit; counter held at 0.
  - Sync value differs from stable: enter COUNTING, counter increments every cycle while it differs.
  - Sync value returns equal to stable before the count completes: counter clears, back to STABLE, no output change.
  - Counter reaches DEBOUNCE_CYCLES-1 while still differing: stable bit takes the new value, counter clears, back to STABLE.
  - Total latency = SYNC_STAGES + DEBOUNCE_CYCLES + 1 edges.
  - Counter width = $clog2(DEBOUNCE_CYCLES); it never wraps.
- Bit 4, PLTRST_DETECTED_REARM_ACM_TIMER:
  - Set when synced pltrst_n = 1 and the previous sample = 0.
  - Because the previous-sample register resets to 1, pltrst_n already high at reset release does not set the bit.
  - Latency SYNC_STAGES+1.
- Bit 5, BMC_SPI_IBB_ACCESS_DETECTED:
  - Set on any cycle where bmc_spi_ibb_access=1; no synchronizer; latency 1.
- Sticky clear:
  - On clr_valid=1, bits 4 and 5 clear where clr_mask bit = 1.
  - Set has priority over clear in the same cycle: the bit stays 1.
  - clr_mask bits other than 4 and 5 are ignored; level bits cannot be cleared.
  - clr_valid with clr_mask=0 has no effect.
- Bits 31:10 are constant 0.
- gpi_1_change:
  - Registered compare of the next and current gpi_1; it pulses in the same cycle the new gpi_1 value first appears.
  - Held 0 on the first cycle after reset release.
- areset mid-operation:
  - All state returns immediately to the reset values above.
  - In-progress debounce counts and pending edges are discarded.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4):
- Reset release with all inputs 0 except force_recovery_n=1 and pltrst_n=1 -> gpi_1 stays 0x40 and gpi_1_change stays 0 for 20 cycles.
- legacy 0->1 at cycle T -> gpi_1[8]=1 at edge T+3 with a single gpi_1_change pulse; hpfr_active and legacy toggling together -> both bits update in the same cycle with one pulse.
- force_recovery_n low for 3 cycles then high -> bit 6 stays 1. Low for 10 cycles -> bit 6 goes 0 exactly 7 edges after the input fall (2 sync + 4 debounce + 1).
- pltrst_n 1->0->1 -> bit 4 sets 3 edges after the rising edge. clr_valid with clr_mask=0x10 -> bit 4 clears next cycle. clr_valid on the same cycle as a new rising edge -> bit 4 remains 1.
- bmc_spi_ibb_access single-cycle pulse -> gpi_1[5]=1 next edge and stays set. clr_mask=0xFFFFFFFF -> only bits 4/5 clear; level bits unchanged; bits 31:10 always 0.
- areset asserted mid-debounce (count=2) and with bit 5 set -> next edge gpi_1=0x40. After release, no stale debounce completes.
